vend_dispenser: RTL and testbench

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vending_pkg.sv | 53 +++++
 rtl/vend_req_fifo.sv | 76 +++++++
 rtl/vend_dispenser.sv | 196 +++++++++++++++++++
 tb/tb_vend_dispenser.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the bottle/change dispenser back end:
//   - default pulse length and coin-ack timeout
//   - change-code constants (code value equals the number of 5 rs coins)
//   - dispenser FSM state encoding
//   - queued request record {bottle, change}
// -----------------------------------------------------------------------------
package vending_pkg;

  localparam int unsigned VEND_CYCLES_DEF = 8;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  localparam logic [1:0] CHG_0  = 2'b00;
  localparam logic [1:0] CHG_5  = 2'b01;
  localparam logic [1:0] CHG_10 = 2'b10;
  localparam logic [1:0] CHG_15 = 2'b11;

  localparam int unsigned REQ_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VEND  = 3'd1,
    ST_EJECT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  typedef struct packed {
    logic       bottle;
    logic [1:0] change;
  } req_t;

  // A cycle is a request when it asks for a bottle or for any change.
  function automatic logic is_request(input logic bottle, input logic [1:0] change);
    return bottle | (change != CHG_0);
  endfunction

  // Number of 5 rs coins owed for a change code.
  function automatic logic [1:0] coins_for(input logic [1:0] change);
    logic [1:0] n;
    case (change)
      CHG_0:   n = 2'd0;
      CHG_5:   n = 2'd1;
      CHG_10:  n = 2'd2;
      CHG_15:  n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// -----------------------------------------------------------------------------
// vend_req_fifo
// Two-entry request queue between the upstream vending FSM and the dispenser.
// A push into a full queue is accepted only when a pop happens in the same
// cycle; otherwise it is discarded (the caller flags the overflow).
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset, empties the queue
//   push_i  - write data_i this cycle
//   pop_i   - discard the head this cycle
//   data_i  - {bottle, change} request to enqueue
//   data_o  - head of queue (valid when empty_o = 0)
//   full_o  - both entries occupied
//   empty_o - no entries occupied
// -----------------------------------------------------------------------------
module vend_req_fifo
  import vending_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REQ_W-1:0] data_i,
  output logic [REQ_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [REQ_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy and compute the next fill level.
  always_comb begin
    do_pop_s  = pop_i & (count_q != 2'd0);
    // When full, the slot being popped frees room for the incoming push.
    do_push_s = push_i & ((count_q != 2'd2) | do_pop_s);
    count_d   = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + 2'd1;
    end else if (!do_push_s && do_pop_s) begin
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Storage, pointers and fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= {REQ_W{1'b0}};
      mem_q[1] <= {REQ_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser
// Executes queued vending transactions: pulses the bottle-release solenoid,
// then pays out change one 5 rs coin at a time through a handshaking hopper.
// A hopper that never acknowledges locks the block in FAULT until reset.
// Parameters:
//   VEND_CYCLES - solenoid pulse length in clk cycles (1..255)
//   ACK_TIMEOUT - cycles to wait for coin_ack before faulting (1..255)
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   bottle_req - upstream asks for a bottle
//   change_req - upstream change code, number of 5 rs coins owed
//   coin_ack   - hopper ejected one coin (only honoured while ejecting)
//   vend_motor - bottle-release solenoid drive
//   coin_eject - request one coin from the hopper
//   done       - one-cycle pulse at the end of a transaction
//   busy       - a transaction (or the fault lock) is in progress
//   overflow   - sticky: a request arrived while the queue was full
//   fault      - sticky: the hopper failed to acknowledge in time
// All outputs are flops loaded from the next-state, so they switch on the
// same edge as the FSM and no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module vend_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned VEND_CYCLES = VEND_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bottle_req,
  input  logic [1:0] change_req,
  input  logic       coin_ack,
  output logic       vend_motor,
  output logic       coin_eject,
  output logic       done,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  // Terminal counts: the counters start at zero on state entry.
  localparam logic [7:0] VEND_LAST = 8'(VEND_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [1:0]       coins_q;
  logic [1:0]       coins_d;
  logic [7:0]       vend_cnt_q;
  logic [7:0]       vend_cnt_d;
  logic [7:0]       tmo_cnt_q;
  logic [7:0]       tmo_cnt_d;

  logic             vend_motor_q;
  logic             coin_eject_q;
  logic             done_q;
  logic             busy_q;
  logic             overflow_q;
  logic             fault_q;

  logic             req_valid_s;
  logic             pop_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [REQ_W-1:0] fifo_data_s;
  req_t             head_s;

  assign req_valid_s = is_request(bottle_req, change_req);
  assign head_s      = req_t'(fifo_data_s);

  vend_req_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_valid_s),
    .pop_i   (pop_s),
    .data_i  ({bottle_req, change_req}),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // A request is lost only if the queue is full and nothing leaves it now.
  assign drop_s = req_valid_s & fifo_full_s & ~pop_s;

  // Next-state, counters and queue pop.
  always_comb begin
    state_d    = state_q;
    coins_d    = coins_q;
    vend_cnt_d = vend_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    pop_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          coins_d    = coins_for(head_s.change);
          vend_cnt_d = 8'd0;
          tmo_cnt_d  = 8'd0;
          if (head_s.bottle) begin
            state_d = ST_VEND;
          end else begin
            state_d = ST_EJECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_VEND: begin
        if (vend_cnt_q == VEND_LAST) begin
          vend_cnt_d = 8'd0;
          tmo_cnt_d  = 8'd0;
          if (coins_q != 2'd0) begin
            state_d = ST_EJECT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          vend_cnt_d = vend_cnt_q + 8'd1;
        end
      end

      ST_EJECT: begin
        // An ack always wins, even on the last allowed cycle.
        if (coin_ack) begin
          coins_d = coins_q - 2'd1;
          state_d = ST_GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      ST_GAP: begin
        tmo_cnt_d = 8'd0;
        if (coins_q != 2'd0) begin
          state_d = ST_EJECT;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      coins_q      <= 2'd0;
      vend_cnt_q   <= 8'd0;
      tmo_cnt_q    <= 8'd0;
      vend_motor_q <= 1'b0;
      coin_eject_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      coins_q      <= coins_d;
      vend_cnt_q   <= vend_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      vend_motor_q <= (state_d == ST_VEND);
      coin_eject_q <= (state_d == ST_EJECT);
      done_q       <= (state_d == ST_DONE);
      busy_q       <= (state_d != ST_IDLE);
      overflow_q   <= overflow_q | drop_s;
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign vend_motor = vend_motor_q;
  assign coin_eject = coin_eject_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser.
// Cycle k is the clock period that ends at rising edge k: inputs present in
// cycle k are sampled at edge k, and outputs after edge k belong to cycle k+1.
// Output vector order everywhere: {vend_motor, coin_eject, done, busy, overflow, fault}.
module tb_vend_dispenser;
  import vending_pkg::*;

  localparam int VC = 8;
  localparam int AT = 255;

  logic       clk;
  logic       reset;
  logic       bottle_req;
  logic [1:0] change_req;
  logic       coin_ack;
  logic       vend_motor;
  logic       coin_eject;
  logic       done;
  logic       busy;
  logic       overflow;
  logic       fault;

  vend_dispenser #(.VEND_CYCLES(VC), .ACK_TIMEOUT(AT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bottle_req (bottle_req),
    .change_req (change_req),
    .coin_ack   (coin_ack),
    .vend_motor (vend_motor),
    .coin_eject (coin_eject),
    .done       (done),
    .busy       (busy),
    .overflow   (overflow),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int motor_hi_cnt = 0;
  int eject_hi_cnt = 0;

  // Transaction-level reference: a queue of pending requests plus countdowns
  // describing what the dispenser is doing for the current transaction.
  logic [2:0] mq[$];
  int m_motor_left = 0;
  int m_coins      = 0;
  int m_age        = 0;
  bit m_ejecting   = 0;
  bit m_gap        = 0;
  bit m_done       = 0;
  bit m_fault      = 0;
  bit m_ovf        = 0;

  function automatic bit m_idle();
    return !(m_motor_left > 0 || m_ejecting || m_gap || m_done || m_fault);
  endfunction

  function automatic void model_step(input logic r, input logic b, input logic [1:0] c, input logic a);
    bit         was_idle;
    bit         popped;
    logic [2:0] head;
    if (r) begin
      mq.delete();
      m_motor_left = 0; m_coins = 0; m_age = 0;
      m_ejecting = 0; m_gap = 0; m_done = 0; m_fault = 0; m_ovf = 0;
      return;
    end
    was_idle = m_idle();
    popped   = was_idle && (mq.size() > 0);
    head     = 3'b000;
    if (popped) head = mq.pop_front();
    if (b || (c != 2'b00)) begin
      if (mq.size() < 2) mq.push_back({b, c});
      else m_ovf = 1;
    end
    if (m_fault) begin
      m_fault = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_motor_left > 0) begin
      m_motor_left--;
      if (m_motor_left == 0) begin
        if (m_coins > 0) begin m_ejecting = 1; m_age = 0; end
        else m_done = 1;
      end
    end else if (m_ejecting) begin
      if (a) begin
        m_coins--; m_ejecting = 0; m_gap = 1;
      end else begin
        m_age++;
        if (m_age >= AT) begin m_ejecting = 0; m_fault = 1; end
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (m_coins > 0) begin m_ejecting = 1; m_age = 0; end
      else m_done = 1;
    end else if (popped) begin
      m_coins = int'(head[1:0]);
      if (head[2]) m_motor_left = VC;
      else begin m_ejecting = 1; m_age = 0; end
    end
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_motor_left > 0, m_ejecting, m_done, !m_idle(), m_ovf, m_fault};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {vend_motor, coin_eject, done, busy, overflow, fault};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then compare.
  task automatic tick(input logic r, input logic b, input logic [1:0] c, input logic a);
    reset = r; bottle_req = b; change_req = c; coin_ack = a;
    @(posedge clk);
    model_step(r, b, c, a);
    #1;
    chk("model", 32'(dut_vec()), 32'(model_vec()));
    if (vend_motor === 1'b1) motor_hi_cnt++;
    if (coin_eject === 1'b1) eject_hi_cnt++;
  endtask

  typedef struct {
    logic       r;
    logic       b;
    logic [1:0] c;
    logic       a;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic r, input logic b, input logic [1:0] c, input logic a, input logic [5:0] e);
    vec_t v;
    v.r = r; v.b = b; v.c = c; v.a = a; v.exp = e;
    return v;
  endfunction

  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_MOT  = 6'b100100;
  localparam logic [5:0] O_EJ   = 6'b010100;
  localparam logic [5:0] O_GAP  = 6'b000100;
  localparam logic [5:0] O_DN   = 6'b001100;

  int         cur_m;
  int         cur_c;
  int         cnt;
  bit         seen;
  int         dm[$];
  int         dc[$];
  logic       aa;
  logic       bb;
  logic [1:0] cc;

  initial begin
    // ---- table: reset, bottle only, bottle + 5 rs ------------------------
    tbl.push_back(mkv(1'b1, 1'b0, 2'b00, 1'b0, O_IDLE));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_IDLE));
    tbl.push_back(mkv(1'b0, 1'b1, 2'b00, 1'b0, O_IDLE));      // queued, pop next edge
    for (int k = 0; k < 8; k++)                               // ack during VEND is ignored
      tbl.push_back(mkv(1'b0, 1'b0, 2'b00, (k == 3), O_MOT));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_DN));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_IDLE));
    tbl.push_back(mkv(1'b0, 1'b1, 2'b01, 1'b0, O_IDLE));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_MOT));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_EJ));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_EJ));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_EJ));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b1, O_GAP));       // ack in 3rd eject cycle
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_DN));
    tbl.push_back(mkv(1'b0, 1'b0, 2'b00, 1'b0, O_IDLE));
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].b, tbl[i].c, tbl[i].a);
      chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // ---- 15 rs change, no bottle: three handshakes, ack delays 0/1/2 ------
    motor_hi_cnt = 0;
    tick(1'b0, 1'b0, 2'b11, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    chk("c15_first_eject", 32'(coin_eject), 32'd1);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < k; j++) begin
        tick(1'b0, 1'b0, 2'b00, 1'b0);
        chk($sformatf("c15_hold%0d", k), 32'(coin_eject), 32'd1);
      end
      tick(1'b0, 1'b0, 2'b00, 1'b1);
      chk($sformatf("c15_gap%0d", k), 32'(dut_vec()), 32'(O_GAP));
      tick(1'b0, 1'b0, 2'b00, 1'b0);
      if (k < 2) chk($sformatf("c15_regap%0d", k), 32'(dut_vec()), 32'(O_EJ));
      else       chk("c15_done", 32'(dut_vec()), 32'(O_DN));
    end
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    chk("c15_no_motor", 32'(motor_hi_cnt), 32'd0);

    // ---- overflow: three requests while busy -----------------------------
    cur_m = 0; cur_c = 0;
    tick(1'b0, 1'b1, 2'b00, 1'b0);                            // A: bottle only
    for (int i = 1; i < 160; i++) begin
      bb = 1'b0; cc = 2'b00;
      if (i == 2) cc = 2'b01;                                 // B: 5 rs
      else if (i == 3) begin bb = 1'b1; cc = 2'b10; end       // C: bottle + 10 rs
      else if (i == 4) cc = 2'b11;                            // D: must be dropped
      aa = coin_eject;
      tick(1'b0, bb, cc, aa);
      if (i == 3) chk("ovf_before", 32'(overflow), 32'd0);
      if (i == 4) chk("ovf_set", 32'(overflow), 32'd1);
      if (aa) cur_c++;
      if (vend_motor) cur_m++;
      if (done) begin dm.push_back(cur_m); dc.push_back(cur_c); cur_m = 0; cur_c = 0; end
    end
    chk("ovf_txn_count", 32'(dm.size()), 32'd3);
    while (dm.size() < 3) begin dm.push_back(-1); dc.push_back(-1); end
    chk("ovf_A_motor", 32'(dm[0]), 32'd8);
    chk("ovf_A_coins", 32'(dc[0]), 32'd0);
    chk("ovf_B_motor", 32'(dm[1]), 32'd0);
    chk("ovf_B_coins", 32'(dc[1]), 32'd1);
    chk("ovf_C_motor", 32'(dm[2]), 32'd8);
    chk("ovf_C_coins", 32'(dc[2]), 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // ---- ack timeout -> FAULT lock ---------------------------------------
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    tick(1'b0, 1'b0, 2'b10, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    cnt = (coin_eject === 1'b1) ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 2'b00, 1'b0);
      if (fault === 1'b1) break;
      if (coin_eject === 1'b1) cnt++;
    end
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_eject_cycles", 32'(cnt), 32'd255);
    chk("tmo_eject_off", 32'(coin_eject), 32'd0);
    motor_hi_cnt = 0; eject_hi_cnt = 0;
    tick(1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 2'b00, (i % 3 == 0));
    chk("tmo_no_motor", 32'(motor_hi_cnt), 32'd0);
    chk("tmo_no_eject", 32'(eject_hi_cnt), 32'd0);
    chk("tmo_locked", 32'(dut_vec()), 32'(6'b000101));

    // ---- reset in 4th VEND cycle, with a simultaneous request -------------
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    chk("rst_clears_fault", 32'(dut_vec()), 32'(O_IDLE));
    tick(1'b0, 1'b1, 2'b00, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 1'b0);                            // VEND cycle 1 follows
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 1'b0);
    chk("rst_in_vend", 32'(vend_motor), 32'd1);
    tick(1'b1, 1'b1, 2'b01, 1'b0);                            // 4th VEND cycle
    chk("rst_outputs", 32'(dut_vec()), 32'(O_IDLE));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b00, 1'b0);
    chk("rst_fifo_empty", 32'(busy), 32'd0);
    cur_m = 0; cur_c = 0; seen = 0;
    tick(1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 60; i++) begin
      aa = coin_eject;
      tick(1'b0, 1'b0, 2'b00, aa);
      if (aa) cur_c++;
      if (vend_motor) cur_m++;
      if (done) begin seen = 1; break; end
    end
    chk("post_rst_done", 32'(seen), 32'd1);
    chk("post_rst_motor", 32'(cur_m), 32'd8);
    chk("post_rst_coins", 32'(cur_c), 32'd1);

    // ---- randomized traffic against the reference ------------------------
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r  = ($urandom_range(0, 599) == 0);
      bb = 1'b0; cc = 2'b00;
      if ($urandom_range(0, 9) == 0) begin
        bb = 1'($urandom_range(0, 1));
        cc = 2'($urandom_range(0, 3));
      end
      aa = ($urandom_range(0, 2) == 0);
      tick(r, bb, cc, aa);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
